// File: rtl/shared_bus_arbiter_if.sv
// Handshake and bus bundle between the requesters and the shared-bus arbiter.
interface shared_bus_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 2
) ();
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            done;
    logic [NUM_REQ*DATA_WIDTH-1:0] data_in;
    logic [NUM_REQ-1:0]            grant;
    logic [SEL_WIDTH-1:0]          sel;
    logic [DATA_WIDTH-1:0]         data_out;
    logic                          bus_valid;
    logic                          timeout;

    // Requester side drives requests, completion strobes and data.
    modport master (
        output req, done, data_in,
        input  grant, sel, data_out, bus_valid, timeout
    );

    // Arbiter side consumes requests and drives grant and the shared bus.
    modport slave (
        input  req, done, data_in,
        output grant, sel, data_out, bus_valid, timeout
    );
endinterface

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter with bounded hold time steering one requester's data
// onto a shared bus. Grant/sel/timeout are registered; data_out is a pure mux.
module shared_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 2,
    parameter int MAX_HOLD   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    shared_bus_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, OWN} state_t;

    state_t                 state_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic [SEL_WIDTH-1:0]   sel_q;
    logic [SEL_WIDTH-1:0]   ptr_q;
    logic [7:0]             hold_cnt_q;
    logic                   timeout_q;

    logic                   win_found_d;
    logic [SEL_WIDTH-1:0]   win_sel_d;
    logic [SEL_WIDTH-1:0]   ptr_d;
    logic                   owner_done;
    logic                   owner_drop;
    logic                   hold_expired;

    logic [DATA_WIDTH-1:0]  slice [NUM_REQ];

    // Unpack the requester data words so the mux can index them by sel.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign slice[gi] = bus.data_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin search: first requesting index at or after ptr, wrapping.
    always_comb begin
        logic [SEL_WIDTH:0] cand;
        win_found_d = 1'b0;
        win_sel_d   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (SEL_WIDTH+1)'(k);
            if (cand >= (SEL_WIDTH+1)'(NUM_REQ)) begin
                cand = cand - (SEL_WIDTH+1)'(NUM_REQ);
            end
            if (!win_found_d && bus.req[cand[SEL_WIDTH-1:0]]) begin
                win_found_d = 1'b1;
                win_sel_d   = cand[SEL_WIDTH-1:0];
            end
        end
    end

    // Priority pointer after the current owner releases: owner+1, wrapping.
    always_comb begin
        logic [SEL_WIDTH:0] nxt;
        nxt = {1'b0, sel_q} + (SEL_WIDTH+1)'(1);
        if (nxt >= (SEL_WIDTH+1)'(NUM_REQ)) begin
            nxt = '0;
        end
        ptr_d = nxt[SEL_WIDTH-1:0];
    end

    assign owner_done   = bus.done[sel_q];
    assign owner_drop   = !bus.req[sel_q];
    assign hold_expired = (hold_cnt_q == 8'(MAX_HOLD));

    // Arbitration FSM: claim the winner from IDLE, release on done, request
    // drop or hold expiry; a release always returns through one IDLE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        state_q    <= OWN;
                        grant_q    <= NUM_REQ'(1) << win_sel_d;
                        sel_q      <= win_sel_d;
                        hold_cnt_q <= 8'd1;
                    end
                end
                OWN: begin
                    if (owner_done || owner_drop || hold_expired) begin
                        state_q   <= IDLE;
                        grant_q   <= '0;
                        ptr_q     <= ptr_d;
                        // Expiry only signals when nothing else ended the grant.
                        timeout_q <= !(owner_done || owner_drop);
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.bus_valid = |grant_q;
    assign bus.timeout   = timeout_q;
    // Shared bus: winner's word while granted, zeros otherwise.
    assign bus.data_out  = bus.bus_valid ? slice[sel_q] : '0;
endmodule
